// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory responder: READ (0x03) / WRITE (0x02) with a 24-bit address,
// auto-incrementing byte stream, plus a backdoor port for preload and checking.
module spi_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter bit READ_ONLY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs_n,
    output logic                 miso,
    output logic                 busy,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_RD,
        S_WR,
        S_IGN
    } state_t;

    logic [7:0] mem_q [DEPTH];

    logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic       sclk_hist_q, cs_hist_q;

    state_t               state_q;
    logic [4:0]           bit_cnt_q;
    logic [7:0]           shift_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 is_wr_q;
    logic                 load_pend_q;
    logic                 miso_q;
    logic                 busy_q;

    // cs_n sync flops reset to "selected" so a chip select held low across
    // reset never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 2'b00;
            sclk_hist_q <= 1'b0;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b00;
            cs_hist_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            sclk_hist_q <= sclk_sync_q[1];
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            cs_sync_q   <= {cs_sync_q[0], cs_n};
            cs_hist_q   <= cs_sync_q[1];
        end
    end

    logic                 sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic [7:0]           shift_in;
    logic [ADDR_BITS-1:0] addr_in;
    logic                 spi_we;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_hist_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_hist_q;
    assign cs_rise   = cs_sync_q[1] & ~cs_hist_q;
    assign cs_fall   = ~cs_sync_q[1] & cs_hist_q;
    assign mosi_s    = mosi_sync_q[1];
    assign shift_in  = {shift_q[6:0], mosi_s};
    assign addr_in   = {addr_q[ADDR_BITS-2:0], mosi_s};
    assign spi_we    = !rst && !cs_rise && (state_q == S_WR) && sclk_rise && (bit_cnt_q == 5'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 8'd0;
            addr_q      <= '0;
            is_wr_q     <= 1'b0;
            load_pend_q <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else if (cs_rise) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 5'd0;
            load_pend_q <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q   <= S_CMD;
                        bit_cnt_q <= 5'd0;
                        busy_q    <= 1'b1;
                    end
                end
                S_CMD: if (sclk_rise) begin
                    shift_q <= shift_in;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_q <= 5'd0;
                        if (shift_in == 8'h03) begin
                            state_q <= S_ADDR;
                            is_wr_q <= 1'b0;
                        end else if (shift_in == 8'h02 && !READ_ONLY) begin
                            state_q <= S_ADDR;
                            is_wr_q <= 1'b1;
                        end else begin
                            state_q <= S_IGN;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                S_ADDR: if (sclk_rise) begin
                    addr_q <= addr_in;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_q <= 5'd0;
                        if (is_wr_q) begin
                            state_q <= S_WR;
                        end else begin
                            // First data bit goes out now; the master samples it on the next rise.
                            state_q     <= S_RD;
                            shift_q     <= mem_q[addr_in];
                            miso_q      <= mem_q[addr_in][7];
                            load_pend_q <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                S_RD: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q   <= 5'd0;
                            addr_q      <= addr_q + ADDR_ONE;
                            load_pend_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end else if (sclk_fall) begin
                        // bit_cnt 0 without a pending load is the fall right after entry.
                        if (load_pend_q) begin
                            shift_q     <= mem_q[addr_q];
                            miso_q      <= mem_q[addr_q][7];
                            load_pend_q <= 1'b0;
                        end else if (bit_cnt_q != 5'd0) begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            miso_q  <= shift_q[6];
                        end
                    end
                end
                S_WR: if (sclk_rise) begin
                    shift_q <= shift_in;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_q <= 5'd0;
                        addr_q    <= addr_q + ADDR_ONE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                S_IGN:   miso_q <= 1'b0;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // SPI write is applied last so it wins a same-address collision with the backdoor.
    always_ff @(posedge clk) begin
        if (bd_we)
            mem_q[bd_addr] <= bd_wdata;
        if (spi_we)
            mem_q[addr_q] <= shift_in;
    end

    assign bd_rdata = mem_q[bd_addr];
    assign miso     = miso_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: a read/write instance and a read-only instance share the SPI bus.
module tb_spi_mem_responder;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, mosi = 1'b0, cs0_n = 1'b1, cs1_n = 1'b1;
    logic       miso0, miso1, busy0, busy1;
    logic       bd_we0 = 1'b0, bd_we1 = 1'b0;
    logic [7:0] bd_addr = 8'd0, bd_wdata = 8'd0, rd0, rd1;

    always #5 clk = ~clk;

    spi_mem_responder #(.ADDR_BITS(8), .READ_ONLY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs0_n),
        .miso(miso0), .busy(busy0), .bd_we(bd_we0), .bd_addr(bd_addr),
        .bd_wdata(bd_wdata), .bd_rdata(rd0)
    );

    spi_mem_responder #(.ADDR_BITS(8), .READ_ONLY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs1_n),
        .miso(miso1), .busy(busy1), .bd_we(bd_we1), .bd_addr(bd_addr),
        .bd_wdata(bd_wdata), .bd_rdata(rd1)
    );

    int   errors = 0;
    int   checks = 0;
    int   busy_low;
    logic miso_seen;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [63:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic sb_pop_chk(input logic [63:0] act);
        sb_t e;
        if (sbq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got %0h expected none", act);
        end else begin
            e = sbq.pop_front();
            chk(e.name, act, e.exp);
        end
    endtask

    task automatic bd_write(input int d, input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        bd_addr  = a;
        bd_wdata = v;
        if (d == 0) bd_we0 = 1'b1; else bd_we1 = 1'b1;
        @(negedge clk);
        bd_we0 = 1'b0;
        bd_we1 = 1'b0;
    endtask

    task automatic bd_read(input int d, input logic [7:0] a, output logic [7:0] v);
        bd_addr = a;
        #1;
        v = (d == 0) ? rd0 : rd1;
    endtask

    task automatic set_cs(input int d, input logic v);
        if (d == 0) cs0_n = v; else cs1_n = v;
    endtask

    task automatic spi_bits(input int d, input int n, input logic [63:0] tx, output logic [63:0] rx);
        logic m, b;
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = tx[n-1-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            m = (d == 0) ? miso0 : miso1;
            b = (d == 0) ? busy0 : busy1;
            rx = {rx[62:0], m};
            if (b !== 1'b1) busy_low++;
            if (m !== 1'b0) miso_seen = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic spi_txn(input int d, input int n, input logic [63:0] tx, output logic [63:0] rx);
        busy_low  = 0;
        miso_seen = 1'b0;
        @(negedge clk);
        set_cs(d, 1'b0);
        repeat (HALF) @(negedge clk);
        spi_bits(d, n, tx, rx);
        repeat (HALF) @(negedge clk);
        set_cs(d, 1'b1);
        repeat (3) @(negedge clk);
        chk("busy_drop", 64'((d == 0) ? busy0 : busy1), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    vec_t        vecs[4];
    logic [63:0] rx, tx, mask;
    logic [7:0]  v;

    initial begin
        vecs[0] = '{"rd_deadbeef", 8'h03, 24'h000010, 4, 32'hDEADBEEF};
        vecs[1] = '{"rd_wrap",     8'h03, 24'h0000FF, 2, 32'h0000AA55};
        vecs[2] = '{"rd_trunc",    8'h03, 24'h0123FF, 1, 32'h000000AA};
        vecs[3] = '{"rd_mid",      8'h03, 24'h000012, 2, 32'h0000BEEF};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy0", 64'(busy0), 64'd0);
        chk("reset_miso0", 64'(miso0), 64'd0);
        chk("reset_busy1", 64'(busy1), 64'd0);

        bd_write(0, 8'h10, 8'hDE);
        bd_write(0, 8'h11, 8'hAD);
        bd_write(0, 8'h12, 8'hBE);
        bd_write(0, 8'h13, 8'hEF);
        bd_write(0, 8'hFF, 8'hAA);
        bd_write(0, 8'h00, 8'h55);
        bd_write(0, 8'h30, 8'h5A);
        bd_write(1, 8'h20, 8'h77);
        bd_write(1, 8'h21, 8'h88);

        // Read vectors: expected data queued as the transfer is driven.
        for (int k = 0; k < 4; k++) begin
            sb_push(vecs[k].name, 64'(vecs[k].exp));
            tx   = 64'({vecs[k].cmd, vecs[k].addr}) << (8 * vecs[k].nbytes);
            mask = (64'd1 << (8 * vecs[k].nbytes)) - 64'd1;
            spi_txn(0, 32 + 8 * vecs[k].nbytes, tx, rx);
            sb_pop_chk(rx & mask);
            chk({vecs[k].name, "_busy"}, 64'(busy_low), 64'd0);
        end

        // Write two bytes, then confirm through backdoor and SPI read-back.
        sb_push("wr_0x20", 64'h12);
        sb_push("wr_0x21", 64'h34);
        spi_txn(0, 48, {8'h02, 24'h000020, 8'h12, 8'h34}, rx);
        bd_read(0, 8'h20, v); sb_pop_chk(64'(v));
        bd_read(0, 8'h21, v); sb_pop_chk(64'(v));
        spi_txn(0, 48, {8'h03, 24'h000020, 16'h0}, rx);
        chk("wr_readback", rx & 64'hFFFF, 64'h1234);

        // Read-only instance ignores WRITE.
        spi_txn(1, 48, {8'h02, 24'h000020, 8'h12, 8'h34}, rx);
        chk("ro_miso_quiet", 64'(miso_seen), 64'd0);
        bd_read(1, 8'h20, v); chk("ro_0x20", 64'(v), 64'h77);
        bd_read(1, 8'h21, v); chk("ro_0x21", 64'(v), 64'h88);

        // Abort a write after 5 data bits.
        spi_txn(0, 37, {8'h02, 24'h000030, 5'b10110}, rx);
        bd_read(0, 8'h30, v); chk("abort_keep", 64'(v), 64'h5A);
        chk("abort_miso", 64'(miso0), 64'd0);
        spi_txn(0, 40, {8'h03, 24'h000030, 8'h0}, rx);
        chk("abort_readback", rx & 64'hFF, 64'h5A);

        // Unknown command followed by 40 clocks.
        spi_txn(0, 48, {8'h9F, 40'hFF_FFFF_FFFF}, rx);
        chk("unk_miso_quiet", 64'(miso_seen), 64'd0);
        chk("unk_busy", 64'(busy_low), 64'd0);
        bd_read(0, 8'h10, v); chk("unk_no_change", 64'(v), 64'hDE);
        spi_txn(0, 40, {8'h03, 24'h000010, 8'h0}, rx);
        chk("unk_then_read", rx & 64'hFF, 64'hDE);

        // Reset during RD_DATA while cs_n stays low.
        busy_low  = 0;
        miso_seen = 1'b0;
        @(negedge clk);
        cs0_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_bits(0, 32, {32'h03000013}, rx);
        repeat (4) @(negedge clk);
        chk("pre_rst_miso", 64'(miso0), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_miso", 64'(miso0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        busy_low = 0;
        spi_bits(0, 8, 64'h0, rx);
        chk("rst_no_reenter", 64'(busy_low), 64'd8);
        repeat (HALF) @(negedge clk);
        cs0_n = 1'b1;
        repeat (8) @(negedge clk);
        spi_txn(0, 40, {8'h03, 24'h000013, 8'h0}, rx);
        chk("rst_then_read", rx & 64'hFF, 64'hEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
